// File: rtl/ifetch_pkg.sv
// Shared constants and the fetch queue entry type for the instruction fetch front end.
package ifetch_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] instr;
        logic [XLEN_DEFAULT-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Bus between the fetch stage and its surroundings: redirect, decode handshake, memory load port.
interface ifetch_queue_if #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 4096
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] pc_plus4;
    logic            imem_we;
    logic [AW-1:0]   imem_waddr;
    logic [XLEN-1:0] imem_wdata;

    modport master (
        output redirect_valid, redirect_pc, out_ready, imem_we, imem_waddr, imem_wdata,
        input  out_valid, instr, instr_pc, pc_plus4
    );

    modport slave (
        input  redirect_valid, redirect_pc, out_ready, imem_we, imem_waddr, imem_wdata,
        output out_valid, instr, instr_pc, pc_plus4
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous circular FIFO with flush; head is presented combinationally from the read slot.
module ifetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [63:0],
    parameter int  CW      = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  entry_t        push_data,
    output entry_t        head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          slots [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = slots[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage has no reset; pointers and count alone define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push && !RESET && !flush) begin
            slots[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled fetch stage: PC sequencer, read-first instruction memory with one-cycle read,
// and a credit-controlled prefetch queue feeding decode.
module ifetch_queue #(
    parameter int              XLEN        = ifetch_pkg::XLEN_DEFAULT,
    parameter int              IMEM_DEPTH  = 4096,
    parameter int              QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input logic            CLK,
    input logic            RESET,
    ifetch_queue_if.slave  bus
);

    import ifetch_pkg::*;

    localparam int AW  = $clog2(IMEM_DEPTH);
    localparam int CW  = $clog2(QUEUE_DEPTH + 1);
    localparam int CW1 = CW + 1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] mem [IMEM_DEPTH];
    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [CW1-1:0]  credit_used;
    entry_t          head;
    entry_t          push_entry;
    logic            head_valid;
    logic            pop;
    logic            issue;
    logic            unused_ok;

    assign head_valid = (count != '0);
    assign pop        = head_valid && bus.out_ready;

    // Entries already owned (queued plus in flight, minus the one leaving) must leave room for the new read.
    assign credit_used = CW1'(count) + CW1'(inflight) - CW1'(pop);
    assign issue       = !RESET && !bus.redirect_valid && (credit_used < CW1'(QUEUE_DEPTH));

    always_ff @(posedge CLK) begin
        if (bus.imem_we) begin
            mem[bus.imem_waddr] <= bus.imem_wdata;
        end
        if (issue) begin
            mem_data <= mem[fpc[AW+1:2]];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            fpc      <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc         <= fpc + XLEN'(4);
                inflight_pc <= fpc;
            end
        end
    end

    assign push_entry = '{instr: mem_data, pc: inflight_pc};

    ifetch_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t),
        .CW      (CW)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .flush     (bus.redirect_valid),
        .push      (inflight),
        .pop       (pop),
        .push_data (push_entry),
        .head      (head),
        .count     (count)
    );

    assign bus.out_valid = head_valid;
    assign bus.instr     = head_valid ? head.instr : XLEN'(NOP);
    assign bus.instr_pc  = head_valid ? head.pc : '0;
    assign bus.pc_plus4  = head_valid ? head.pc + XLEN'(4) : '0;

    // PC bits outside the word index are deliberately ignored.
    assign unused_ok = ^{bus.redirect_pc[1:0], fpc[XLEN-1:AW+2], fpc[1:0]};

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized and directed checks of ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;

    localparam int XLEN = 32;
    localparam int IMEM_DEPTH = 16;
    localparam int QUEUE_DEPTH = 4;
    localparam int AW = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } m_entry_t;

    logic CLK;
    logic RESET;

    ifetch_queue_if #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH)) bus_if ();

    ifetch_queue #(
        .XLEN        (XLEN),
        .IMEM_DEPTH  (IMEM_DEPTH),
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .RESET_PC    (32'h0)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    int check_count = 0;
    int pass_count = 0;

    logic [31:0] m_mem [IMEM_DEPTH];
    m_entry_t    mq [$];
    bit          m_inflight;
    m_entry_t    m_pending;
    logic [31:0] m_fpc;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference: the spec's rules applied to a queue, an in-flight slot and a fetch PC.
    task automatic modelEdge(input bit rst, input bit redir, input logic [31:0] rpc,
                             input bit rdy, input bit we, input logic [3:0] wa, input logic [31:0] wd);
        bit pop;
        int occ;
        pop = (mq.size() != 0) && rdy;
        if (rst) begin
            mq.delete();
            m_inflight = 0;
            m_fpc = 32'h0;
        end else if (redir) begin
            mq.delete();
            m_inflight = 0;
            m_fpc = rpc & 32'hFFFF_FFFC;
        end else begin
            occ = mq.size() + int'(m_inflight) - int'(pop);
            if (pop) void'(mq.pop_front());
            if (m_inflight) mq.push_back(m_pending);
            if (occ < QUEUE_DEPTH) begin
                m_pending = '{instr: m_mem[m_fpc[AW+1:2]], pc: m_fpc};
                m_inflight = 1;
                m_fpc = m_fpc + 32'd4;
            end else begin
                m_inflight = 0;
            end
        end
        if (we) m_mem[wa] = wd;
    endtask

    task automatic applyStimulus(input bit rst, input bit redir, input logic [31:0] rpc,
                                 input bit rdy, input bit we, input logic [3:0] wa, input logic [31:0] wd);
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        RESET = rst;
        bus_if.redirect_valid = redir;
        bus_if.redirect_pc = rpc;
        bus_if.out_ready = rdy;
        bus_if.imem_we = we;
        bus_if.imem_waddr = wa;
        bus_if.imem_wdata = wd;
        @(posedge CLK);
        modelEdge(rst, redir, rpc, rdy, we, wa, wd);
        #1;
        e_instr = (mq.size() != 0) ? mq[0].instr : 32'h0;
        e_pc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
        e_p4    = (mq.size() != 0) ? mq[0].pc + 32'd4 : 32'h0;
        checkOutput("model_valid", 32'(bus_if.out_valid), 32'(mq.size() != 0));
        checkOutput("model_instr", bus_if.instr, e_instr);
        checkOutput("model_pc", bus_if.instr_pc, e_pc);
        checkOutput("model_pc_plus4", bus_if.pc_plus4, e_p4);
    endtask

    initial begin
        logic [31:0] exp_pc;
        bit found;

        for (int i = 0; i < IMEM_DEPTH; i++) begin
            applyStimulus(1, 0, 0, 1, 1, 4'(i), 32'h100 + i);
        end
        checkOutput("reset_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("reset_instr", bus_if.instr, 32'd0);

        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("boot_valid_edge1", 32'(bus_if.out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            checkOutput("boot_valid", 32'(bus_if.out_valid), 32'd1);
            checkOutput("boot_pc", bus_if.instr_pc, 32'(4 * k));
            checkOutput("boot_instr", bus_if.instr, 32'h100 + 32'(k));
            checkOutput("boot_pc_plus4", bus_if.pc_plus4, 32'(4 * k + 4));
        end

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_head_valid", 32'(bus_if.out_valid), 32'd1);
        checkOutput("stall_head_pc", bus_if.instr_pc, 32'h0);
        exp_pc = 32'd4;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            checkOutput("drain_valid", 32'(bus_if.out_valid), 32'd1);
            checkOutput("drain_pc", bus_if.instr_pc, exp_pc);
            exp_pc += 32'd4;
        end

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h23, 1, 0, 0, 0);
        checkOutput("redir_valid_e0", 32'(bus_if.out_valid), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("redir_valid_e1", 32'(bus_if.out_valid), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("redir_target_pc", bus_if.instr_pc, 32'h20);
        checkOutput("redir_target_instr", bus_if.instr, 32'h108);

        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            if (bus_if.out_valid && bus_if.instr_pc == 32'h40) found = 1;
        end
        checkOutput("wrap_reached", 32'(found), 32'd1);
        checkOutput("wrap_instr", bus_if.instr, 32'h100);

        applyStimulus(0, 1, 32'h14, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 4'd5, 32'hDEAD);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("rfirst_pc", bus_if.instr_pc, 32'h14);
        checkOutput("rfirst_old_data", bus_if.instr, 32'h105);
        applyStimulus(0, 1, 32'h14, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("refetch_new_data", bus_if.instr, 32'hDEAD);

        applyStimulus(0, 1, 32'h0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("midreset_valid", 32'(bus_if.out_valid), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("midreset_valid_e1", 32'(bus_if.out_valid), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("midreset_restart_pc", bus_if.instr_pc, 32'h0);
        checkOutput("midreset_restart_instr", bus_if.instr, 32'h100);

        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, $urandom,
                          $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20,
                          4'($urandom_range(0, 15)), $urandom);
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
